// File: rtl/fence_unit_if.sv
// fence_unit_if: bundle of every non-clock, non-reset signal of fence_unit.
//   Pipeline side: in_valid/in_ready/in_kind/in_pred/in_succ/in_pc, kill,
//                  done_valid/done_illegal, stall_cycles.
//   Store buffer:  sb_drain_req/sb_empty.
//   I-cache:       ic_inv_req/ic_inv_ack.
//   Fetch:         flush/redirect_pc.
// The fence_unit itself connects through the slave modport; the pipeline,
// memory-side models and testbenches drive it through the master modport.

package fence_pkg;
  typedef enum logic [1:0] {
    fk_invalid = 2'd0,
    fk_fence   = 2'd1,
    fk_fence_i = 2'd2
  } fence_kind_t;
endpackage

interface fence_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  fence_pkg::fence_kind_t in_kind;
  logic [3:0]             in_pred;
  logic [3:0]             in_succ;
  logic [XLEN-1:0]        in_pc;
  logic                   kill;
  logic                   sb_drain_req;
  logic                   sb_empty;
  logic                   ic_inv_req;
  logic                   ic_inv_ack;
  logic                   flush;
  logic [XLEN-1:0]        redirect_pc;
  logic                   done_valid;
  logic                   done_illegal;
  logic [CNT_W-1:0]       stall_cycles;

  modport slave (
    input  in_valid, in_kind, in_pred, in_succ, in_pc, kill, sb_empty, ic_inv_ack,
    output in_ready, sb_drain_req, ic_inv_req, flush, redirect_pc,
           done_valid, done_illegal, stall_cycles
  );

  modport master (
    output in_valid, in_kind, in_pred, in_succ, in_pc, kill, sb_empty, ic_inv_ack,
    input  in_ready, sb_drain_req, ic_inv_req, flush, redirect_pc,
           done_valid, done_illegal, stall_cycles
  );
endinterface

// File: rtl/fence_unit.sv
// fence_unit: execute-stage sequencer for RV32I FENCE / FENCE.I.
// Accepts one decoded fence at a time, drains the store buffer when the
// predecessor/successor sets demand ordering, invalidates the I-cache and
// redirects fetch for FENCE.I, then reports completion (or an illegal
// encoding). Also keeps a saturating count of cycles spent outside IDLE.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active low
//   bus  - fence_unit_if.slave (handshake, store buffer, I-cache, fetch,
//          completion and stall counter signals)

module fence_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  fence_unit_if.slave  bus
);
  import fence_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    INVAL,
    FLUSH,
    DONE
  } state_t;

  localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  state_t          state_nx;
  logic            is_fi_q;
  logic            illegal_q;
  logic            abort_q;
  logic            abort_nx;
  logic [XLEN-1:0] pc_q;
  logic [CNT_W-1:0] stall_q;
  logic            accept;
  logic            orders;
  logic            pred_unused;

  // PI and PR never force a store-buffer drain; only PO/PW matter here.
  assign pred_unused = ^{bus.in_pred[3], bus.in_pred[1]};

  assign accept = bus.in_valid && bus.in_ready;

  // Does the offered fence need the store buffer drained first?
  always_comb begin
    orders = 1'b0;
    case (bus.in_kind)
      fk_fence:   orders = (bus.in_pred[0] || bus.in_pred[2]) && (bus.in_succ != 4'b0000);
      fk_fence_i: orders = 1'b1;
      default:    orders = 1'b0;
    endcase
  end

  // Next state. A kill in INVAL is only remembered: the invalidate handshake
  // has to finish before the unit may return to IDLE.
  always_comb begin
    state_nx = state;
    abort_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = orders ? DRAIN : DONE;
      end
      DRAIN: begin
        if (bus.kill)          state_nx = IDLE;
        else if (bus.sb_empty) state_nx = is_fi_q ? INVAL : DONE;
      end
      INVAL: begin
        abort_nx = abort_q || bus.kill;
        if (bus.ic_inv_ack) begin
          state_nx = abort_nx ? IDLE : FLUSH;
          abort_nx = 1'b0;
        end
      end
      FLUSH:   state_nx = IDLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, captured fence fields and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      abort_q   <= 1'b0;
      is_fi_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      stall_q   <= '0;
    end else begin
      state   <= state_nx;
      abort_q <= abort_nx;
      if (state != IDLE && stall_q != CNT_MAX) stall_q <= stall_q + CNT_ONE;
      if (accept) begin
        is_fi_q   <= (bus.in_kind == fk_fence_i);
        illegal_q <= !((bus.in_kind == fk_fence) || (bus.in_kind == fk_fence_i));
        pc_q      <= bus.in_pc;
      end
    end
  end

  // Outputs follow the registered state; a squash in the final cycle
  // suppresses the completion and the redirect.
  assign bus.in_ready     = (state == IDLE) && !bus.kill;
  assign bus.sb_drain_req = (state == DRAIN);
  assign bus.ic_inv_req   = (state == INVAL);
  assign bus.flush        = (state == FLUSH) && !bus.kill;
  assign bus.done_valid   = ((state == FLUSH) || (state == DONE)) && !bus.kill;
  assign bus.done_illegal = (state == DONE) && illegal_q && !bus.kill;
  assign bus.redirect_pc  = (state == FLUSH) ? (pc_q + PC_STEP) : '0;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_fence_unit.sv
// tb_fence_unit: randomized, scoreboard-checked bench for fence_unit.
// The driver pushes the expected completion of each fence (computed from
// the fence rules with plain arithmetic) into a queue on acceptance; a
// monitor pops and compares whenever the DUT signals completion. A second
// instance with a 4-bit counter exercises stall-counter saturation.

module tb_fence_unit;
  import fence_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fence_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
  fence_unit_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  fence_unit #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fence_unit #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic        illegal;
    logic        do_flush;
    logic [31:0] target;
    int          latency;
    int          drain_cyc;
    int          inv_cyc;
    longint      stall_at_done;
    int          accept_cycle;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad = 0;
  int     cycle = 0;
  longint model_stall = 0;
  int     sb_delay = 0;
  int     ack_delay = 0;
  int     drain_seen = 0;
  int     inv_seen = 0;
  int     mon_drain = 0;
  int     mon_inv = 0;
  logic   prev_done = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Expected outcome of one fence from the ordering rules: drain when the
  // fence orders prior stores against anything later (or for FENCE.I),
  // invalidate plus redirect for FENCE.I, one closing cycle for the rest.
  function automatic exp_t model_fence(input fence_kind_t kind, input logic [3:0] pred,
                                       input logic [3:0] succ, input logic [31:0] pc,
                                       input int s, input int a);
    exp_t e;
    bit   is_fi;
    bit   ordering;
    is_fi       = (kind == fk_fence_i);
    ordering    = is_fi || (kind == fk_fence && (pred[0] || pred[2]) && succ != 4'b0000);
    e.illegal   = (kind == fk_invalid);
    e.do_flush  = is_fi;
    e.target    = pc + 32'd4;
    e.drain_cyc = ordering ? 1 + s : 0;
    e.inv_cyc   = is_fi ? 1 + a : 0;
    e.latency   = e.drain_cyc + e.inv_cyc + 1;
    e.stall_at_done = model_stall + longint'(e.latency) - 1;
    e.accept_cycle  = 0;
    return e;
  endfunction

  // Store buffer and I-cache responder: sb_empty rises after sb_delay drain
  // cycles, ack pulses ack_delay cycles into the invalidate. Outside their
  // request windows both are random noise the unit must ignore.
  initial begin
    bus.sb_empty   = 1'b1;
    bus.ic_inv_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.sb_drain_req) begin
        bus.sb_empty = (drain_seen >= sb_delay);
        drain_seen++;
      end else begin
        drain_seen   = 0;
        bus.sb_empty = 1'($urandom_range(0, 1));
      end
      if (bus.ic_inv_req) begin
        bus.ic_inv_ack = (inv_seen == ack_delay);
        inv_seen++;
      end else begin
        inv_seen       = 0;
        bus.ic_inv_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: samples mid-cycle, pops one expectation per completion.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("flush pairing", longint'(bus.flush && !bus.done_valid), 0);
      if (exp_q.size() == 0) begin
        mon_drain = 0;
        mon_inv   = 0;
        checkOutput("idle done_valid", longint'(bus.done_valid), 0);
        checkOutput("idle flush", longint'(bus.flush), 0);
      end else begin
        if (bus.sb_drain_req) mon_drain++;
        if (bus.ic_inv_req)   mon_inv++;
        if (bus.done_valid) begin
          mon_e = exp_q.pop_front();
          checkOutput("done one-cycle", longint'(prev_done), 0);
          checkOutput("done_illegal", longint'(bus.done_illegal), longint'(mon_e.illegal));
          checkOutput("flush", longint'(bus.flush), longint'(mon_e.do_flush));
          if (mon_e.do_flush) checkOutput("redirect_pc", longint'(bus.redirect_pc), longint'(mon_e.target));
          checkOutput("latency", longint'(cycle - mon_e.accept_cycle), longint'(mon_e.latency));
          checkOutput("drain cycles", longint'(mon_drain), longint'(mon_e.drain_cyc));
          checkOutput("inval cycles", longint'(mon_inv), longint'(mon_e.inv_cyc));
          checkOutput("stall at done", longint'(bus.stall_cycles), mon_e.stall_at_done);
          mon_drain = 0;
          mon_inv   = 0;
        end
      end
      prev_done = bus.done_valid;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Offer one fence; returns at the start of the cycle after acceptance.
  task automatic applyStimulus(input fence_kind_t kind, input logic [3:0] pred,
                               input logic [3:0] succ, input logic [31:0] pc,
                               input int s, input int a, input bit expect_done);
    int   waited;
    exp_t e;
    waited    = 0;
    sb_delay  = s;
    ack_delay = a;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_pred  = pred;
    bus.in_succ  = succ;
    bus.in_pc    = pc;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept", longint'(bus.in_ready), 1);
    if (expect_done && bus.in_ready) begin
      e = model_fence(kind, pred, succ, pc, s, a);
      e.accept_cycle = cycle;
      exp_q.push_back(e);
      model_stall += longint'(e.latency);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_kind  = fence_kind_t'(2'($urandom_range(0, 2)));
    bus.in_pred  = 4'($urandom);
    bus.in_succ  = 4'($urandom);
    bus.in_pc    = $urandom;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("completion", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fence_kind_t kind;
    logic [3:0]  pred;
    logic [3:0]  succ;
    logic [31:0] pc;
    int          n4;

    bus.in_valid  = 1'b0;
    bus.in_kind   = fk_fence;
    bus.in_pred   = 4'b0000;
    bus.in_succ   = 4'b0000;
    bus.in_pc     = 32'h0;
    bus.kill      = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_kind  = fk_fence;
    bus4.in_pred  = 4'b0000;
    bus4.in_succ  = 4'b0000;
    bus4.in_pc    = 32'h0;
    bus4.kill     = 1'b0;
    bus4.sb_empty = 1'b1;
    bus4.ic_inv_ack = 1'b0;

    // Reset for two cycles and check the idle state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready", longint'(bus.in_ready), 1);
    checkOutput("reset sb_drain_req", longint'(bus.sb_drain_req), 0);
    checkOutput("reset ic_inv_req", longint'(bus.ic_inv_req), 0);
    checkOutput("reset flush", longint'(bus.flush), 0);
    checkOutput("reset done_valid", longint'(bus.done_valid), 0);
    checkOutput("reset done_illegal", longint'(bus.done_illegal), 0);
    checkOutput("reset redirect_pc", longint'(bus.redirect_pc), 0);
    checkOutput("reset stall_cycles", longint'(bus.stall_cycles), 0);

    $display("[TB] directed fences");
    applyStimulus(fk_fence, 4'b0010, 4'b0010, 32'h0000_1000, 0, 0, 1'b1);
    waitIdle();
    checkOutput("stall after non-ordering", longint'(bus.stall_cycles), model_stall);
    applyStimulus(fk_fence, 4'b0001, 4'b0011, 32'h0000_2000, 3, 0, 1'b1);
    waitIdle();
    applyStimulus(fk_fence_i, 4'b0000, 4'b0000, 32'hFFFF_FFFC, 0, 2, 1'b1);
    waitIdle();
    applyStimulus(fk_invalid, 4'b1111, 4'b1111, 32'h0000_3000, 0, 0, 1'b1);
    waitIdle();
    checkOutput("stall after directed", longint'(bus.stall_cycles), model_stall);

    $display("[TB] kill while idle");
    @(posedge clk);
    #1;
    bus.kill     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_kind  = fk_fence;
    bus.in_pred  = 4'b0001;
    bus.in_succ  = 4'b0001;
    @(negedge clk);
    checkOutput("kill blocks in_ready", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("no accept under kill", longint'(bus.sb_drain_req), 0);
    checkOutput("ready after idle kill", longint'(bus.in_ready), 1);
    checkOutput("stall after idle kill", longint'(bus.stall_cycles), model_stall);

    $display("[TB] kill during drain");
    applyStimulus(fk_fence, 4'b0001, 4'b0001, 32'h0000_4000, 10, 0, 1'b0);
    @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(negedge clk);
    checkOutput("drain at kill", longint'(bus.sb_drain_req), 1);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    checkOutput("drain dropped after kill", longint'(bus.sb_drain_req), 0);
    checkOutput("ready after drain kill", longint'(bus.in_ready), 1);
    model_stall += 2;
    checkOutput("stall after drain kill", longint'(bus.stall_cycles), model_stall);

    $display("[TB] kill during invalidate");
    applyStimulus(fk_fence_i, 4'b0000, 4'b0000, 32'h0000_5000, 0, 3, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(negedge clk);
    checkOutput("inval at kill", longint'(bus.ic_inv_req), 1);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("inval held until ack", longint'(bus.ic_inv_req), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("inval released", longint'(bus.ic_inv_req), 0);
    checkOutput("idle after abort", longint'(bus.in_ready), 1);
    model_stall += 1 + 0 + 1 + 3;
    checkOutput("stall after inval kill", longint'(bus.stall_cycles), model_stall);

    $display("[TB] random fences");
    for (int i = 0; i < 40; i++) begin
      kind = fence_kind_t'(2'($urandom_range(0, 2)));
      pred = 4'($urandom);
      succ = 4'($urandom);
      pc   = (i % 8 == 7) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(kind, pred, succ, pc, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      waitIdle();
    end
    checkOutput("stall after random", longint'(bus.stall_cycles), model_stall);

    $display("[TB] reset during drain");
    applyStimulus(fk_fence, 4'b0100, 4'b1000, 32'h0000_6000, 10, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    model_stall = 0;
    checkOutput("drain dropped by reset", longint'(bus.sb_drain_req), 0);
    checkOutput("ready after reset", longint'(bus.in_ready), 1);
    checkOutput("stall cleared by reset", longint'(bus.stall_cycles), model_stall);

    $display("[TB] narrow counter saturation");
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b1;
    bus4.in_kind  = fk_fence;
    bus4.in_pred  = 4'b0001;
    bus4.in_succ  = 4'b0001;
    bus4.sb_empty = 1'b0;
    @(negedge clk);
    checkOutput("narrow accept", longint'(bus4.in_ready), 1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    n4 = 10;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("narrow count", longint'(bus4.stall_cycles), longint'((n4 > 15) ? 15 : n4));
    n4 = 20;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("narrow saturated", longint'(bus4.stall_cycles), longint'((n4 > 15) ? 15 : n4));
    bus4.sb_empty = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("narrow held", longint'(bus4.stall_cycles), 15);
    checkOutput("narrow idle", longint'(bus4.in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
